// File: rtl/loopback_pkg.sv
// Shared state encoding, LFSR constants and helpers for loopback_lane_checker.
package loopback_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [31:0] sat_max(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] cap
    );
        logic [31:0] m;
        m = (a > b) ? a : b;
        return (m > cap) ? cap : m;
    endfunction

endpackage

// File: rtl/loopback_lane_checker_lane_sync.sv
// NUM_CH-wide, STAGES-deep synchroniser for the asynchronous response lanes.
module lane_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/loopback_lane_checker.sv
// Drives stimulus lanes through an external loopback, checks per-lane parity, latency and timeouts.
// Define LOOPBACK_LFSR_EN to toggle lanes with a 16-bit LFSR pattern instead of all ones.
module loopback_lane_checker
    import loopback_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter logic [NUM_CH-1:0] INV_MASK    = 4'b0101,
    parameter int unsigned       NUM_ITER    = 16,
    parameter int unsigned       TIMEOUT     = 64,
    parameter int unsigned       LAT_W       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    localparam int unsigned      ITER_W      = $clog2(NUM_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NUM_CH-1:0] stim,
    input  logic [NUM_CH-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NUM_CH-1:0] err_mask,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [LAT_W-1:0]  max_lat
);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] resp_s;
    logic [NUM_CH-1:0] expected;
    logic [NUM_CH-1:0] pat;
    logic [LAT_W-1:0]  lat;
    logic              match;
    logic              timeout;
    logic              last_iter;

    lane_sync #(
        .WIDTH  (NUM_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (resp),
        .q     (resp_s)
    );

    assign expected  = stim ^ INV_MASK;
    assign match     = (resp_s == expected);
    assign timeout   = (32'(lat) == TIMEOUT - 1);
    assign last_iter = (32'(iter_cnt) + 32'd1 == NUM_ITER);

`ifdef LOOPBACK_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if ((state == IDLE || state == DONE) && start)
            lfsr <= LFSR_SEED;
        else if (state == DRIVE)
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    // A zero slice would toggle nothing and stall the iteration, so fall back to all ones.
    assign pat = (NUM_CH'(lfsr) == '0) ? '1 : NUM_CH'(lfsr);
`else
    assign pat = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = WAIT;
            WAIT:       if (match || timeout) state_nxt = CHECK;
            CHECK:      state_nxt = (last_iter || err_mask != '0) ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim     <= '0;
            lat      <= '0;
            err_mask <= '0;
            iter_cnt <= '0;
            max_lat  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_mask <= '0;
                        iter_cnt <= '0;
                        max_lat  <= '0;
                    end
                end
                DRIVE: begin
                    stim <= stim ^ pat;
                    lat  <= '0;
                end
                WAIT: begin
                    // Match takes priority over a coincident timeout.
                    if (!match) begin
                        if (timeout)        err_mask <= resp_s ^ expected;
                        else if (lat != '1) lat      <= lat + 1'b1;
                    end
                end
                CHECK: begin
                    max_lat  <= LAT_W'(sat_max(32'(max_lat), 32'(lat), 32'({LAT_W{1'b1}})));
                    iter_cnt <= iter_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
        done = (state == DONE);
        pass = (state == DONE) && (err_mask == '0);
    end

endmodule

// File: doc/loopback_lane_checker.md
Name: loopback_lane_checker

Overview:
- Parametrised successor to the single-chain inverter shoelace bench.
- Drives NUM_CH stimulus lanes out to the switch-level simulator (prsim) and receives NUM_CH response lanes back.
- Each lane carries a compile-time inversion parity. The block checks every iteration, measures round-trip latency in clocks and flags lanes that time out.
- Sits on the Verilog side of co-simulation benches, clocked by the bench clock generator.

Parameters:
- NUM_CH, 4: number of stimulus/response lane pairs.
- INV_MASK, 4'b0101 (width NUM_CH): bit i=1 means lane i returns inverted (odd inverter count).
- NUM_ITER, 16: drive/check iterations per run.
- TIMEOUT, 64: WAIT cycles before an iteration is declared failed.
- LAT_W, 8: width of the latency counter and the max_lat output.
- SYNC_STAGES, 2: flop stages on each resp lane, minimum 2.

Ports:
- clk, in, 1: bench clock; all state on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a run; honoured only in IDLE or DONE.
- stim, out, NUM_CH: stimulus lanes to prsim.
- resp, in, NUM_CH: response lanes from prsim; asynchronous.
- busy, out, 1: high in DRIVE/WAIT/CHECK.
- done, out, 1: high in DONE.
- pass, out, 1: valid while done; 1 iff err_mask==0.
- err_mask, out, NUM_CH: lanes that mismatched at timeout.
- iter_cnt, out, $clog2(NUM_ITER+1): completed iterations, including a failed one.
- max_lat, out, LAT_W: largest latency recorded in this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stim=0, sync flops=0, busy=done=pass=0, err_mask=0, iter_cnt=0, max_lat=0, lat=0. Reset takes effect immediately, including mid-run.
- Synchroniser: resp passes through SYNC_STAGES flops to give resp_s. expected = stim ^ INV_MASK. match = (resp_s == expected), all lanes compared together.
- IDLE: on start go to DRIVE and clear err_mask, iter_cnt, max_lat, done, pass. stim is not cleared; it keeps its current value.
- DRIVE (1 cycle): stim <= stim ^ pat, lat <= 0, go to WAIT. pat = all ones unless the optional feature is enabled.
- WAIT:
  - match: go to CHECK.
  - else if lat==TIMEOUT-1: err_mask <= resp_s ^ expected, go to CHECK.
  - else lat <= lat+1.
  - match and timeout in the same cycle: match wins.
- CHECK (1 cycle):
  - max_lat <= max(max_lat, lat); lat saturates at 2^LAT_W-1, never wraps.
  - iter_cnt <= iter_cnt+1.
  - Go to DONE if iter_cnt+1==NUM_ITER or err_mask!=0; otherwise go to DRIVE.
- DONE: done=1, pass=(err_mask==0). Outputs hold until start, which behaves exactly as start from IDLE.
- start while busy is ignored, with no effect on any state.
- Latency definition: lat=0 in the first WAIT cycle. With a zero-delay external loopback, the recorded lat equals SYNC_STAGES.

Optional Feature:
- Macro: LOOPBACK_LFSR_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on start and advances once per DRIVE. pat = LFSR[NUM_CH-1:0], forced to all ones if that value is zero. Untoggled lanes are still checked for stability.
- Undefined: pat is all ones and no LFSR logic is present.

Decomposition:
- Package loopback_pkg holds:
  - state encoding IDLE/DRIVE/WAIT/CHECK/DONE (3 bits);
  - LFSR seed and tap constants;
  - a saturating-max helper function.
- Sub-module lane_sync: NUM_CH-wide, SYNC_STAGES-deep synchroniser with async active-low reset. It is instantiated once.

Test Plan:
1. NUM_CH=4, INV_MASK=0101, zero-delay inverter/buffer model, start -> done=1, pass=1, err_mask=0, iter_cnt=16, max_lat=2.
2. resp[2] stuck at 0 -> iteration 1 passes (expected 1010). Iteration 2 (expected 0101) times out after 64 WAIT cycles -> err_mask=0100, iter_cnt=2, pass=0.
3. Lane 1 delayed 10 clocks, others zero-delay -> pass=1, max_lat=12.
4. rst_n pulsed low mid-WAIT -> all outputs 0 in the same cycle. A new start then passes the run of scenario 1.
5. start pulsed in DRIVE and in WAIT -> ignored, iter_cnt still ends at 16. start in DONE -> counters cleared and a new run completes.
6. LOOPBACK_LFSR_EN defined, stim=0 at start -> first DRIVE sets stim=0001 (0xACE1 low nibble). The run passes with the zero-delay model.
